fetch_unit: RTL



---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32E fetch stage: credit-limited in-order word fetch with flush redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        nreset,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_address,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_address,
    input  logic        flush,
    input  logic [31:0] redirect_address,
    output logic        fetch_error
);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]   LAST_P  = PW'(DEPTH - 1);

    logic [31:0]    r_pc;
    logic [CW-1:0]  r_outstanding;
    logic [CW-1:0]  r_drop_count;
    logic           r_fetch_error;

    // Address queue: one entry per outstanding request, kept across flushes so drops stay aligned
    logic [31:0]    r_aq_addr [DEPTH];
    logic [PW-1:0]  r_aq_wr;
    logic [PW-1:0]  r_aq_rd;

    // Output buffer of {instruction, address} pairs waiting for decode
    logic [31:0]    r_ob_data [DEPTH];
    logic [31:0]    r_ob_addr [DEPTH];
    logic [PW-1:0]  r_ob_wr;
    logic [PW-1:0]  r_ob_rd;
    logic [CW-1:0]  r_ob_count;

    logic [CW:0]    w_used;
    logic           w_has_credit;
    logic           w_req_fire;
    logic           w_drop;
    logic           w_ob_push;
    logic           w_ob_pop;
    logic [31:0]    w_resp_addr;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + 1'b1;
    endfunction

    assign w_used          = {1'b0, r_outstanding} + {1'b0, r_ob_count};
    assign w_has_credit    = w_used < DEPTH_C;
    assign mem_req_valid   = w_has_credit && !r_fetch_error && !flush && nreset;
    assign mem_req_address = r_pc;
    assign w_req_fire      = mem_req_valid && mem_req_ready;
    assign w_drop          = r_drop_count != '0;
    assign w_resp_addr     = r_aq_addr[r_aq_rd];
    assign w_ob_push       = mem_resp_valid && !w_drop && !flush;
    assign out_valid       = r_ob_count != '0;
    assign w_ob_pop        = out_valid && out_ready && !flush;
    assign out_instruction = out_valid ? r_ob_data[r_ob_rd] : 32'h0;
    assign out_address     = out_valid ? r_ob_addr[r_ob_rd] : 32'h0;
    assign fetch_error     = r_fetch_error;

    // PC, error flag, drop counter and in-flight count; flush redirects and marks all in-flight work stale
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_pc          <= RESET_PC;
            r_fetch_error <= 1'b0;
            r_drop_count  <= '0;
            r_outstanding <= '0;
        end else begin
            if (flush) begin
                r_pc          <= redirect_address;
                r_fetch_error <= |redirect_address[1:0];
                r_drop_count  <= r_outstanding - CW'(mem_resp_valid);
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (mem_resp_valid && w_drop) begin
                    r_drop_count <= r_drop_count - 1'b1;
                end
            end
            case ({w_req_fire, mem_resp_valid})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Address queue pointers advance on request handshake and on every response
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_aq_wr <= '0;
            r_aq_rd <= '0;
        end else begin
            if (w_req_fire) begin
                r_aq_wr <= f_next(r_aq_wr);
            end
            if (mem_resp_valid) begin
                r_aq_rd <= f_next(r_aq_rd);
            end
        end
    end

    // Address queue storage needs no reset; pointers define validity
    always_ff @(posedge clock) begin
        if (w_req_fire) begin
            r_aq_addr[r_aq_wr] <= r_pc;
        end
    end

    // Output buffer occupancy; flush empties it in one edge
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_ob_wr    <= '0;
            r_ob_rd    <= '0;
            r_ob_count <= '0;
        end else if (flush) begin
            r_ob_wr    <= '0;
            r_ob_rd    <= '0;
            r_ob_count <= '0;
        end else begin
            if (w_ob_push) begin
                r_ob_wr <= f_next(r_ob_wr);
            end
            if (w_ob_pop) begin
                r_ob_rd <= f_next(r_ob_rd);
            end
            case ({w_ob_push, w_ob_pop})
                2'b10:   r_ob_count <= r_ob_count + 1'b1;
                2'b01:   r_ob_count <= r_ob_count - 1'b1;
                default: r_ob_count <= r_ob_count;
            endcase
        end
    end

    // Output buffer storage: instruction word paired with the address it was fetched from
    always_ff @(posedge clock) begin
        if (w_ob_push) begin
            r_ob_data[r_ob_wr] <= mem_resp_data;
            r_ob_addr[r_ob_wr] <= w_resp_addr;
        end
    end

    // Credit accounting guarantees the buffer has room for every accepted response
    a_no_overflow: assert property (@(posedge clock) disable iff (!nreset)
        !(w_ob_push && !w_ob_pop && (r_ob_count == DEPTH_C[CW-1:0])));

    // Memory must never return more responses than requests issued
    a_resp_matches_req: assert property (@(posedge clock) disable iff (!nreset)
        !(mem_resp_valid && (r_outstanding == '0)));

endmodule
